// File: rtl/qpmm_final_reduce.sv
// Final reduction of a redundant QPMM product Z (0 <= Z < 4P) to R = Z mod P through
// two limb-serial conditional subtractors (2P, then P) and a credit-guarded FWFT FIFO.
// Optional: QPMM_REDUCE_RANGE_CHECK_EN adds sticky err_range for Z >= 4P.
module qpmm_final_reduce #(
  parameter int W     = 256,
  parameter int LIMB  = 64,
  parameter logic [W-1:0] P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter int TAGW  = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_z,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [W-1:0]            out_r,
  output logic [TAGW-1:0]         out_tag,
  input  logic                    out_ready,
  output logic                    err_ovf,
  output logic [$clog2(DEPTH):0]  inflight
`ifdef QPMM_REDUCE_RANGE_CHECK_EN
  , output logic                  err_range
`endif
);

  localparam int NL     = W / LIMB;
  localparam int STAGES = 2 * NL + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [W-1:0] P2 = P << 1;

  logic acc, push, pop;

  // Stage 0 is the input register; select 2 is combinational off the last stage.
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][W-1:0]    a_q, d_q, a_n, d_n;
  logic [STAGES:0]           b_q, b_n;
  logic [STAGES:0][TAGW-1:0] tag_q;
  int                        limb;
  logic [LIMB-1:0]           kl;
  logic [LIMB:0]             diff;
`ifdef QPMM_REDUCE_RANGE_CHECK_EN
  logic [STAGES:0]           c_q, c_n;
  logic [LIMB:0]             diff2;
`endif

  assign acc = in_valid && in_ready;

  always_comb begin
    a_n  = '0;
    d_n  = '0;
    b_n  = '0;
    limb = 0;
    kl   = '0;
    diff = '0;
`ifdef QPMM_REDUCE_RANGE_CHECK_EN
    c_n   = '0;
    diff2 = '0;
`endif
    a_n[0] = in_z;
    for (int k = 1; k <= STAGES; k++) begin
      a_n[k] = a_q[k-1];
      d_n[k] = d_q[k-1];
      b_n[k] = b_q[k-1];
      if (k == NL + 1) begin
        // Select 1: a borrow means Z < 2P, keep Z.
        a_n[k] = b_q[k-1] ? a_q[k-1] : d_q[k-1];
        d_n[k] = '0;
        b_n[k] = 1'b0;
      end else begin
        limb = (k <= NL) ? k - 1 : k - NL - 2;
        kl   = (k <= NL) ? P2[limb*LIMB +: LIMB] : P[limb*LIMB +: LIMB];
        diff = {1'b0, a_q[k-1][limb*LIMB +: LIMB]} - {1'b0, kl} - {{LIMB{1'b0}}, b_q[k-1]};
        d_n[k][limb*LIMB +: LIMB] = diff[LIMB-1:0];
        b_n[k] = diff[LIMB];
`ifdef QPMM_REDUCE_RANGE_CHECK_EN
        // Parallel borrow-only chain for R1 - 2P during phase 2.
        if (k > NL + 1) begin
          diff2  = {1'b0, a_q[k-1][limb*LIMB +: LIMB]} - {1'b0, P2[limb*LIMB +: LIMB]}
                   - {{LIMB{1'b0}}, c_q[k-1]};
          c_n[k] = diff2[LIMB];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_n;
    d_q   <= d_n;
    b_q   <= b_n;
    tag_q <= {tag_q[STAGES-1:0], in_tag};
`ifdef QPMM_REDUCE_RANGE_CHECK_EN
    c_q   <= c_n;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], acc};
  end

  // Select 2 feeds the FIFO write port directly.
  logic [W-1:0] r_sel;
  assign r_sel = b_q[STAGES] ? a_q[STAGES] : d_q[STAGES];
  assign push  = vld_pipe[STAGES];

  logic [W-1:0]    mem_r [DEPTH];
  logic [TAGW-1:0] mem_t [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;

  assign out_valid = (cnt != '0);
  assign out_r     = mem_r[rd_ptr];
  assign out_tag   = mem_t[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr] <= r_sel;
      mem_t[wr_ptr] <= tag_q[STAGES];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // inflight never exceeds DEPTH (a power of two), so its MSB alone flags "full".
  assign in_ready = ~inflight[AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      err_ovf  <= 1'b0;
    end else begin
      case ({acc, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (in_valid && !in_ready) err_ovf <= 1'b1;
    end
  end

`ifdef QPMM_REDUCE_RANGE_CHECK_EN
  // No borrow on R1 - 2P means R1 >= 2P, i.e. Z was out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_range <= 1'b0;
    else if (vld_pipe[STAGES] && !c_q[STAGES]) err_range <= 1'b1;
  end
`endif

endmodule
